// File: rtl/cnn_ctrl_pkg.sv
// cnn_ctrl_pkg: shared state encodings and field-slice helper for CNN control blocks
`ifndef CNN_CTRL_PKG_SV
`define CNN_CTRL_PKG_SV
`define CNN_FIELD(v, i, w) v[(i)*(w) +: (w)]
package cnn_ctrl_pkg;
  typedef enum logic [1:0] {
    LNC_IDLE = 2'd0,
    LNC_RUN  = 2'd1,
    LNC_FIN  = 2'd2
  } lnc_state_t;
endpackage
`endif

// File: rtl/loop_dim_counter.sv
// loop_dim_counter: one loop dimension holding its latched bound and a wrap-on-carry index
module loop_dim_counter #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          clear,
  input  logic          carry_in,
  input  logic [CW-1:0] bound_in,
  output logic [CW-1:0] cnt,
  output logic          at_max,
  output logic          carry_out
);
  logic [CW-1:0] bound_q;
  assign at_max    = cnt == bound_q - CW'(1);
  assign carry_out = carry_in && at_max;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt     <= '0;
      bound_q <= '0;
    end else begin
      if (load) bound_q <= bound_in;
      cnt <= (load || clear) ? '0 : carry_in ? (at_max ? '0 : cnt + CW'(1)) : cnt;
    end
endmodule

// File: rtl/loop_nest_counter.sv
// loop_nest_counter: run-time bounded nested loop walker (dim 0 innermost) with carry, last and done
module loop_nest_counter
  import cnn_ctrl_pkg::*;
#(
  parameter int DIMS = 4,
  parameter int CW   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DIMS*CW-1:0] bound,
  input  logic             ena,
  input  logic             clean,
  output logic [DIMS*CW-1:0] cnt,
  output logic             cnt_valid,
  output logic [DIMS-1:0]  wrap,
  output logic             last,
  output logic             busy,
  output logic             done
);
  lnc_state_t state, state_nxt;
  logic [DIMS:0]   carry;
  logic [DIMS-1:0] at_max;
  logic [DIMS-1:0] zero;
  logic            load;
  assign cnt_valid = state == LNC_RUN;
  assign busy      = state != LNC_IDLE;
  assign done      = state == LNC_FIN;
  assign load      = state == LNC_IDLE && start && !clean;
  assign carry[0]  = ena && cnt_valid;
  assign wrap      = carry[DIMS:1];
  assign last      = cnt_valid && &at_max;
  for (genvar g = 0; g < DIMS; g++) begin : g_dim
    assign zero[g] = `CNN_FIELD(bound, g, CW) == '0;
    loop_dim_counter #(.CW(CW)) u_dim (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .clear    (clean),
      .carry_in (carry[g]),
      .bound_in (`CNN_FIELD(bound, g, CW)),
      .cnt      (`CNN_FIELD(cnt, g, CW)),
      .at_max   (at_max[g]),
      .carry_out(carry[g+1])
    );
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= LNC_IDLE;
    else state <= state_nxt;
  // an empty dimension skips RUN entirely so no valid cycle is ever emitted
  always_comb begin
    state_nxt = state;
    if (clean) state_nxt = LNC_IDLE;
    else if (state == LNC_IDLE) state_nxt = !start ? LNC_IDLE : |zero ? LNC_FIN : LNC_RUN;
    else if (state == LNC_RUN) state_nxt = (last && ena) ? LNC_FIN : LNC_RUN;
    else state_nxt = LNC_IDLE;
  end
endmodule

// File: tb/tb_loop_nest_counter.sv
// tb_loop_nest_counter: randomized scoreboard bench for loop_nest_counter against an arithmetic model
module tb_loop_nest_counter;
  localparam int DIMS = 3;
  localparam int CW   = 16;
  typedef struct {
    bit                  is_done;
    bit                  empty;
    logic [DIMS*CW-1:0]  cnt;
    bit                  last;
    logic [DIMS-1:0]     wrap;
  } exp_t;
  logic clk = 0, rst_n, start, ena, clean;
  logic [DIMS*CW-1:0] bound, cnt;
  logic cnt_valid, last, busy, done;
  logic [DIMS-1:0] wrap;
  exp_t sb[$];
  exp_t e;
  int n_tests = 0, n_fail = 0;
  bit last_fired = 0;
  always #5 clk = ~clk;
  loop_nest_counter #(.DIMS(DIMS), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bound(bound), .ena(ena), .clean(clean),
    .cnt(cnt), .cnt_valid(cnt_valid), .wrap(wrap), .last(last), .busy(busy), .done(done)
  );
  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction
  function automatic void fail(string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got event expected none", name);
  endfunction
  // model: iteration k maps to mixed-radix digits of k with dim 0 least significant
  task automatic push_sweep(input int b0, input int b1, input int b2);
    exp_t x;
    int p = b0 * b1 * b2;
    for (int k = 0; k < p; k++) begin
      int i0 = k % b0, i1 = (k / b0) % b1, i2 = k / (b0 * b1);
      x.is_done = 0;
      x.empty   = 0;
      x.cnt     = {CW'(i2), CW'(i1), CW'(i0)};
      x.last    = k == p - 1;
      x.wrap[0] = i0 == b0 - 1;
      x.wrap[1] = x.wrap[0] && i1 == b1 - 1;
      x.wrap[2] = x.wrap[1] && i2 == b2 - 1;
      sb.push_back(x);
    end
    x = '{is_done: 1, empty: p == 0, cnt: '0, last: 0, wrap: '0};
    sb.push_back(x);
  endtask
  always @(negedge clk) begin
    if (!rst_n) last_fired = 0;
    else begin
      if (cnt_valid) begin
        if (sb.size() == 0 || sb[0].is_done) fail("unexpected_valid");
        else begin
          e = sb[0];
          chk("cnt", cnt, e.cnt);
          chk("last", last, e.last);
          chk("wrap", wrap, ena ? e.wrap : '0);
          if (ena) void'(sb.pop_front());
        end
      end
      if (done) begin
        if (sb.size() == 0 || !sb[0].is_done) fail("unexpected_done");
        else begin
          if (!sb[0].empty) chk("done_latency", last_fired, 1);
          chk("done_busy", busy, 1);
          void'(sb.pop_front());
        end
      end
      last_fired = cnt_valid && ena && last;
    end
  end
  // mode: 0 ena=1, 1 ena toggling, 2 random ena
  task automatic sweep(input int b0, input int b1, input int b2, input int mode,
                       input int clean_at, input int rst_at, input bit mid);
    int n = 0, cyc = 0;
    bit consumed;
    push_sweep(b0, b1, b2);
    bound = {CW'(b2), CW'(b1), CW'(b0)};
    start = 1;
    ena   = 0;
    @(posedge clk);
    #1 start = 0;
    if (b0 * b1 * b2 == 0) begin
      chk("empty_done", done, 1);
      chk("empty_valid", cnt_valid, 0);
    end
    while (busy) begin
      if (rst_at >= 0 && n == rst_at && cnt_valid) begin
        #1 rst_n = 0;
        #1;
        chk("rst_cnt", cnt, 0);
        chk("rst_valid", cnt_valid, 0);
        chk("rst_wrap", wrap, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        sb.delete();
        ena = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        break;
      end
      ena = mode == 0 ? 1'b1 : mode == 1 ? 1'(cyc % 2 == 0) : 1'($urandom_range(0, 1));
      if (mid && cyc == 3) begin
        start = 1;
        bound = {$urandom, $urandom};
      end
      if (clean_at >= 0 && n == clean_at && cnt_valid) clean = 1;
      consumed = cnt_valid && ena;
      @(posedge clk);
      #1 start = 0;
      if (consumed) n++;
      if (clean) begin
        clean = 0;
        sb.delete();
        chk("clean_busy", busy, 0);
        chk("clean_cnt", cnt, 0);
        chk("clean_done", done, 0);
      end
      if (++cyc > 5000) begin
        fail("timeout");
        break;
      end
    end
    ena = 0;
    @(posedge clk);
    #1 chk("sb_drained", sb.size(), 0);
  endtask
  initial begin
    rst_n = 0; start = 0; ena = 0; clean = 0; bound = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    chk("reset_cnt", cnt, 0);
    chk("reset_valid", cnt_valid, 0);
    chk("reset_wrap", wrap, 0);
    chk("reset_last", last, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    @(posedge clk);
    #1;
    sweep(4, 3, 2, 0, -1, -1, 0);
    sweep(4, 3, 2, 1, -1, -1, 0);
    sweep(5, 0, 7, 0, -1, -1, 0);
    sweep(4, 3, 2, 0, 10, -1, 0);
    sweep(4, 3, 2, 0, -1, -1, 0);
    sweep(4, 3, 2, 2, -1, -1, 1);
    sweep(4, 3, 2, 0, -1, 5, 0);
    repeat (2) @(posedge clk);
    #1 chk("post_rst_idle", busy, 0);
    sweep(1, 1, 1, 0, -1, -1, 0);
    for (int r = 0; r < 25; r++) begin
      int b0 = $urandom_range(0, 7) == 0 ? 0 : $urandom_range(1, 4);
      sweep(b0, $urandom_range(1, 4), $urandom_range(1, 3), $urandom_range(0, 2),
            $urandom_range(0, 5) == 0 ? $urandom_range(0, 8) : -1, -1, 1'($urandom_range(0, 1)));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
